// File: rtl/div_pkg.sv
// div_pkg: shared constants for the sequential restoring divider.
package div_pkg;
  localparam int WIDTH_DEF = 3;
  typedef logic [2:0] estado_t;
  localparam estado_t ST_IDLE  = 3'd0;
  localparam estado_t ST_LOAD  = 3'd1;
  localparam estado_t ST_SHIFT = 3'd2;
  localparam estado_t ST_SUB   = 3'd3;
  localparam estado_t ST_DONE  = 3'd4;
endpackage

// File: rtl/divisor_secuencial_if.sv
// divisor_secuencial_if: start/operand/result bundle of the divider.
// DivZero exists only when DIV_ZERO_FLAG_EN is defined.
interface divisor_secuencial_if #(parameter int WIDTH = 3);
  logic             Init;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             Done;
`ifdef DIV_ZERO_FLAG_EN
  logic             DivZero;
`endif
  modport master(output Init, A, B, input Quotient, Remainder, Done
`ifdef DIV_ZERO_FLAG_EN
    , input DivZero
`endif
  );
  modport slave(input Init, A, B, output Quotient, Remainder, Done
`ifdef DIV_ZERO_FLAG_EN
    , output DivZero
`endif
  );
endinterface

// File: rtl/div_paso_restaura.sv
// div_paso_restaura: one restoring step, compares R against D and forms R-D.
module div_paso_restaura #(parameter int WIDTH = 3) (
  input  logic [WIDTH:0] r,
  input  logic [WIDTH:0] d,
  output logic           ge,
  output logic [WIDTH:0] dif
);
  assign ge  = r >= d;
  assign dif = r - d;
endmodule

// File: rtl/divisor_secuencial.sv
// divisor_secuencial: unsigned sequential restoring divider, falling-edge clocked.
// Defining DIV_ZERO_FLAG_EN adds DivZero and a one-step exit for a zero divisor.
module divisor_secuencial
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic Clock,
  input  logic Reset,
  divisor_secuencial_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  estado_t          state, state_nx;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q, d, q_nx;
  logic [CW-1:0]    cnt;
  logic             ge, dz_load, last;
  logic [WIDTH:0]   dif;
`ifdef DIV_ZERO_FLAG_EN
  assign dz_load = bus.B == '0;
`else
  assign dz_load = 1'b0;
`endif
  assign last = cnt == CW'(1);
  // Q was shifted left in SHIFT, so bit 0 is free for the new quotient bit
  assign q_nx = q | WIDTH'(ge);
  div_paso_restaura #(.WIDTH(WIDTH)) u_paso (.r(r), .d({1'b0, d}), .ge(ge), .dif(dif));
  always_ff @(negedge Clock)
    state <= !Reset ? ST_IDLE : state_nx;
  always_comb begin
    state_nx = ST_IDLE;
    case (state)
      ST_IDLE:  state_nx = bus.Init ? ST_LOAD : ST_IDLE;
      ST_LOAD:  state_nx = dz_load ? ST_DONE : ST_SHIFT;
      ST_SHIFT: state_nx = ST_SUB;
      ST_SUB:   state_nx = last ? ST_DONE : ST_SHIFT;
      ST_DONE:  state_nx = bus.Init ? ST_DONE : ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end
  always_comb bus.Done = state == ST_DONE;
  always_ff @(negedge Clock) begin
    if (!Reset) begin
      q             <= '0;
      d             <= '0;
      r             <= '0;
      cnt           <= '0;
      bus.Quotient  <= '0;
      bus.Remainder <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          q   <= bus.A;
          d   <= bus.B;
          r   <= '0;
          cnt <= CW'(WIDTH);
          if (dz_load) begin
            bus.Quotient  <= '1;
            bus.Remainder <= bus.A;
          end
        end
        ST_SHIFT: begin
          r <= {r[WIDTH-1:0], q[WIDTH-1]};
          q <= q << 1;
        end
        ST_SUB: begin
          r   <= ge ? dif : r;
          q   <= q_nx;
          cnt <= cnt - CW'(1);
          if (last) begin
            bus.Quotient  <= q_nx;
            bus.Remainder <= ge ? dif[WIDTH-1:0] : r[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end
`ifdef DIV_ZERO_FLAG_EN
  always_ff @(negedge Clock)
    if (!Reset) bus.DivZero <= 1'b0;
    else if (state == ST_LOAD) bus.DivZero <= dz_load;
`endif
endmodule

// File: tb/tb_divisor_secuencial.sv
// tb_divisor_secuencial: vector table, corner sequences and random/sweep runs
// against an arithmetic reference of the divider.
module tb_divisor_secuencial;
  import div_pkg::*;
  localparam int W = WIDTH_DEF;
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  always #5 Clock = ~Clock;
  divisor_secuencial_if #(.WIDTH(W)) bus ();
  divisor_secuencial #(.WIDTH(W)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));
  typedef struct {
    int a;
    int b;
    int q;
    int r;
  } vec_t;
  vec_t tbl[6];
  function automatic int lat(input int b);
`ifdef DIV_ZERO_FLAG_EN
    return b == 0 ? 1 : 2 * W + 1;
`else
    return 2 * W + 1;
`endif
  endfunction
  function automatic int ref_q(input int a, input int b);
    return b == 0 ? (1 << W) - 1 : a / b;
  endfunction
  function automatic int ref_r(input int a, input int b);
    return b == 0 ? a : a % b;
  endfunction
  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  task automatic run(input int a, input int b, input int eq, input int er);
    int n;
    string tag;
    tag = $sformatf("%0d/%0d", a, b);
    @(posedge Clock);
    bus.A = W'(a);
    bus.B = W'(b);
    bus.Init = 1'b1;
    n = -1;
    do begin
      @(negedge Clock);
      n++;
      @(posedge Clock);
    end while (!bus.Done && n < 40);
    check({tag, " latency"}, n, lat(b));
    check({tag, " quotient"}, int'(bus.Quotient), eq);
    check({tag, " remainder"}, int'(bus.Remainder), er);
`ifdef DIV_ZERO_FLAG_EN
    check({tag, " divzero"}, int'(bus.DivZero), int'(b == 0));
`endif
    @(negedge Clock);
    @(posedge Clock);
    check({tag, " done hold"}, int'(bus.Done), 1);
    bus.Init = 1'b0;
    @(negedge Clock);
    @(posedge Clock);
    check({tag, " done drop"}, int'(bus.Done), 0);
  endtask
  initial begin
    int n, a, b;
    bus.Init = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (2) @(negedge Clock);
    @(posedge Clock);
    check("reset done", int'(bus.Done), 0);
    check("reset quotient", int'(bus.Quotient), 0);
    check("reset remainder", int'(bus.Remainder), 0);
    Reset = 1'b1;
    tbl[0] = '{7, 2, 3, 1};
    tbl[1] = '{6, 3, 2, 0};
    tbl[2] = '{2, 5, 0, 2};
    tbl[3] = '{7, 1, 7, 0};
    tbl[4] = '{5, 0, 7, 5};
    tbl[5] = '{0, 3, 0, 0};
    for (int i = 0; i < 6; i++) run(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r);
    // abort 7/3 with reset landing on edge 4
    @(posedge Clock);
    bus.A = 3'd7;
    bus.B = 3'd3;
    bus.Init = 1'b1;
    repeat (4) @(negedge Clock);
    @(posedge Clock);
    Reset = 1'b0;
    bus.Init = 1'b0;
    @(negedge Clock);
    @(posedge Clock);
    check("abort quotient", int'(bus.Quotient), 0);
    check("abort remainder", int'(bus.Remainder), 0);
    check("abort done", int'(bus.Done), 0);
`ifdef DIV_ZERO_FLAG_EN
    check("abort divzero", int'(bus.DivZero), 0);
`endif
    Reset = 1'b1;
    repeat (3) @(posedge Clock);
    check("abort idle", int'(bus.Done), 0);
    run(7, 7, 1, 0);
    // 6/4 with operands and Init disturbed after LOAD
    @(posedge Clock);
    bus.A = 3'd6;
    bus.B = 3'd4;
    bus.Init = 1'b1;
    n = -1;
    do begin
      @(negedge Clock);
      n++;
      @(posedge Clock);
      if (!bus.Done && n >= 1) begin
        bus.A = 3'd1;
        bus.B = 3'd1;
        bus.Init = n[0];
      end
    end while (!bus.Done && n < 40);
    check("disturb latency", n, 2 * W + 1);
    check("disturb quotient", int'(bus.Quotient), 1);
    check("disturb remainder", int'(bus.Remainder), 2);
    bus.Init = 1'b0;
    repeat (3) @(posedge Clock);
    check("disturb no restart", int'(bus.Done), 0);
    repeat (16) begin
      a = int'($urandom_range(0, 7));
      b = int'($urandom_range(0, 7));
      run(a, b, ref_q(a, b), ref_r(a, b));
    end
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++) begin
        run(x, y, ref_q(x, y), ref_r(x, y));
        if (y != 0) begin
          check($sformatf("sweep %0d/%0d identity", x, y),
                int'(bus.Quotient) * y + int'(bus.Remainder), x);
          check($sformatf("sweep %0d/%0d rem<b", x, y), int'(int'(bus.Remainder) < y), 1);
        end
      end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/divisor_secuencial.md
Name: divisor_secuencial

Overview:
- Sequential restoring divider for the ALU: unsigned A / B, producing Quotient and Remainder.
- Inverse operation of the shift-and-add multiplier; same operand width and a start/done style so the ALU mux and display path treat it identically.
- FSM and datapath live in one module; the per-bit compare/subtract sits in a small combinational sub-module.

Parameters:
- WIDTH, 3, operand width of A, B, Quotient and Remainder.

Ports:
- Clock  input  1  system clock; all registers update on the falling edge.
- Reset  input  1  synchronous, active-low reset; one clock.
- Init  input  1  start request, level-sampled in IDLE only.
- A  input  WIDTH  dividend, captured in LOAD.
- B  input  WIDTH  divisor, captured in LOAD.
- Quotient  output  WIDTH  registered result.
- Remainder  output  WIDTH  registered result.
- Done  output  1  high while FSM is in DONE.
- DivZero  output  1  divisor-was-zero flag; present only with DIV_ZERO_FLAG_EN.

Behaviour:
- Reset (Reset==0 at a falling edge): state=IDLE; Quotient, Remainder, internal R (WIDTH+1 bits), Q, D and iteration counter all 0; Done=0, DivZero=0.
- Reset wins over every other event, including mid-division; the operation is aborted and no partial result is kept.
- States:
  - IDLE: Init==1 -> LOAD; else stay.
  - LOAD: Q=A, D=B, R=0, count=WIDTH -> SHIFT.
  - SHIFT: R={R[WIDTH-1:0],Q[WIDTH-1]}, Q=Q<<1 -> SUB.
  - SUB: if R>=D then R=R-D and Q[0]=1. count=count-1. If count reaches 0: Quotient=Q, Remainder=R[WIDTH-1:0] -> DONE; else -> SHIFT.
  - DONE: hold while Init==1; Init==0 -> IDLE.
- Done is decoded from state==DONE (no extra register).
- Quotient and Remainder keep their last values until the next completion or reset; they are not cleared by LOAD.
- Latency: Init sampled at edge 0 -> Done high after edge 2*WIDTH+1 (edge 7 for WIDTH=3).
- Init and operand changes outside IDLE/LOAD are ignored. A held Init does not retrigger; Init must drop in DONE before a new start.
- Width rule: the compare/subtract uses WIDTH+1 bits. No overflow exists for unsigned operands; results satisfy A = Quotient*B + Remainder for B != 0.
- B==0 without the feature: the algorithm runs normally and yields Quotient=all ones, Remainder=A.

Optional Feature:
- DIV_ZERO_FLAG_EN defined:
  - DivZero port exists.
  - In LOAD, if B==0: Quotient=all ones, Remainder=A, DivZero=1 -> DONE directly (Done high after edge 1).
  - DivZero is cleared in LOAD for a nonzero B and by reset.
- Not defined: no DivZero port; zero divisor takes full latency with the same numeric result.

Decomposition:
- Package div_pkg holds:
  - state encoding constants ST_IDLE, ST_LOAD, ST_SHIFT, ST_SUB, ST_DONE (3-bit);
  - default WIDTH constant.
- Sub-module div_paso_restaura (combinational):
  - inputs R, D;
  - outputs ge flag and R-D, WIDTH+1 bits.

Test Plan:
- Reset low for 2 edges, then A=7, B=2, Init=1 -> Done rises after edge 7; Quotient=3, Remainder=1; Done stays high while Init=1; Init=0 -> IDLE next edge.
- A=6, B=3 -> Quotient=2, Remainder=0. A=2, B=5 -> Quotient=0, Remainder=2. A=7, B=1 -> Quotient=7, Remainder=0.
- A=5, B=0, with DIV_ZERO_FLAG_EN -> Done after edge 1, DivZero=1, Quotient=7, Remainder=5. Without it -> Done after edge 7, Quotient=7, Remainder=5.
- Start 7/3, drive Reset=0 at edge 4 -> all outputs 0, IDLE. Then 7/7 -> Quotient=1, Remainder=0 with normal latency.
- Start 6/4, change A=1 and B=1 and toggle Init during SHIFT/SUB -> result still Quotient=1, Remainder=2; no restart.
- Exhaustive sweep of all 64 A,B pairs (B!=0): check A == Quotient*B + Remainder and Remainder < B.
